// File: rtl/gray_pkg.sv
// Shared width default and binary-to-Gray conversion for the gray counter.
package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  // Adjacent codes differ in exactly one bit: each bit is XORed with its upper neighbour.
  function automatic logic [GRAY_WIDTH-1:0] bin_to_gray(input logic [GRAY_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH-parameterized.
module bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // The package function is sized for the default width; other widths use the same rule inline.
  generate
    if (WIDTH == GRAY_WIDTH) begin : g_pkg
      assign gray_o = bin_to_gray(bin_i);
    end else begin : g_generic
      assign gray_o = bin_i ^ (bin_i >> 1);
    end
  endgenerate

endmodule

// File: rtl/gray.sv
// Enabled binary counter presented as a Gray code, with a sticky wrap flag.
module gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic             Overflow,
  output logic [WIDTH-1:0] Output
);

  // Declaration initializers give defined outputs before the first reset.
  logic [WIDTH-1:0] cnt_q = '0;
  logic             ovf_q = 1'b0;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (En) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {WIDTH{1'b1}}) ovf_d = 1'b1;
    end
  end

  // Reset overrides enable, so a simultaneous wrap never sets the flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (cnt_q),
    .gray_o (Output)
  );

endmodule

// File: tb/tb_gray.sv
// Directed self-checking bench for the 3-bit gray counter.
module tb_gray;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic       Overflow;
  logic [2:0] Output;

  int errors;
  int checks;

  gray #(.WIDTH(3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Overflow (Overflow),
    .Output   (Output)
  );

  // Clock and input defaults
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hand-written Gray sequence for a 3-bit count.
  logic [2:0] gseq [8];
  initial begin
    gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
    gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;
  end

  // Drive inputs mid-cycle, then sample shortly after the rising edge.
  task automatic step(input logic rst, input logic en);
    @(negedge Clk);
    Reset = rst;
    En    = en;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] exp_out, input logic exp_ovf);
    checks++;
    assert (Output === exp_out) else begin
      errors++;
      $error("FAIL %s output: got %b want %b", tag, Output, exp_out);
    end
    checks++;
    assert (Overflow === exp_ovf) else begin
      errors++;
      $error("FAIL %s overflow: got %b want %b", tag, Overflow, exp_ovf);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b0;
    En     = 1'b0;

    // Power-up without reset: defined zero state, no counting.
    #1;
    expect_state("powerup_t0", 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      expect_state("powerup_idle", 3'b000, 1'b0);
    end

    step(1'b1, 1'b0);
    expect_state("reset", 3'b000, 1'b0);

    // Seven enabled edges walk the code up to 100.
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1);
      expect_state($sformatf("count_%0d", i), gseq[i], 1'b0);
    end

    // Wrap sets the sticky flag on the same edge Output returns to 000.
    step(1'b0, 1'b1);
    expect_state("wrap", 3'b000, 1'b1);
    step(1'b0, 1'b1);
    expect_state("post_wrap_1", 3'b001, 1'b1);
    step(1'b0, 1'b1);
    expect_state("post_wrap_2", 3'b011, 1'b1);

    // Disabled edges hold both count and flag.
    step(1'b0, 1'b0);
    expect_state("hold_1", 3'b011, 1'b1);
    step(1'b0, 1'b0);
    expect_state("hold_2", 3'b011, 1'b1);

    step(1'b0, 1'b1);
    expect_state("to_010", 3'b010, 1'b1);
    step(1'b0, 1'b1);
    expect_state("to_110", 3'b110, 1'b1);

    // Reset with enable high: reset wins and clears the flag.
    step(1'b1, 1'b1);
    expect_state("reset_en", 3'b000, 1'b0);
    step(1'b1, 1'b1);
    expect_state("reset_held_1", 3'b000, 1'b0);
    step(1'b1, 1'b1);
    expect_state("reset_held_2", 3'b000, 1'b0);

    step(1'b0, 1'b1);
    expect_state("release_1", 3'b001, 1'b0);
    step(1'b0, 1'b1);
    expect_state("release_2", 3'b011, 1'b0);

    // Run through a second wrap, then one past it to confirm stickiness.
    for (int i = 3; i < 8; i++) begin
      step(1'b0, 1'b1);
      expect_state($sformatf("lap2_%0d", i), gseq[i], 1'b0);
    end
    step(1'b0, 1'b1);
    expect_state("wrap2", 3'b000, 1'b1);
    step(1'b0, 1'b1);
    expect_state("wrap2_plus1", 3'b001, 1'b1);
    step(1'b0, 1'b1);
    expect_state("wrap2_plus2", 3'b011, 1'b1);

    // Mid-sequence reset with enable low, then resume from 000.
    step(1'b1, 1'b0);
    expect_state("mid_reset", 3'b000, 1'b0);
    step(1'b0, 1'b0);
    expect_state("mid_reset_idle", 3'b000, 1'b0);
    step(1'b0, 1'b1);
    expect_state("resume", 3'b001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
